// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the LDPC frame iteration controller.
// Holds the default geometry, the controller state encoding and circulant shift-table helpers.
package ldpc_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int R_DEF      = 5;
  localparam int C_DEF      = 3;
  localparam int D_DEF      = 8;
  localparam int TAB_MAX_W  = 2048;

  typedef enum logic [2:0] {LOAD, CLEAR, RUN, CHECK, OUT} state_t;

  function automatic logic [7:0] shift_of(input logic [TAB_MAX_W-1:0] tab,
                                          input int i, input int j, input int r = R_DEF);
    return tab[(i*r+j)*8 +: 8];
  endfunction

  // Default base matrix: block (i,j) is the identity cyclically shifted by (i*j) mod d.
  function automatic logic [TAB_MAX_W-1:0] default_shift_tab(input int c, input int r, input int d);
    logic [TAB_MAX_W-1:0] t;
    t = '0;
    for (int i = 0; i < c; i++)
      for (int j = 0; j < r; j++)
        t[(i*r+j)*8 +: 8] = 8'((i*j) % d);
    return t;
  endfunction

endpackage

// File: rtl/ldpc_syndrome.sv
// Combinational syndrome of a hard-decision word against the quasi-cyclic base matrix.
// Check (i,k) XORs bit (k+shift(i,j)) mod D of every variable group j.
module ldpc_syndrome import ldpc_pkg::*; #(
  parameter int C = C_DEF,
  parameter int R = R_DEF,
  parameter int D = D_DEF,
  parameter logic [C*R*8-1:0] SHIFT_TAB = (C*R*8)'(default_shift_tab(C, R, D))
) (
  input  logic [R*D-1:0] hard,
  output logic [C*D-1:0] syn,
  output logic           zero
);

  localparam logic [TAB_MAX_W-1:0] TAB = TAB_MAX_W'(SHIFT_TAB);

  always_comb begin
    syn = '0;
    for (int i = 0; i < C; i++)
      for (int k = 0; k < D; k++)
        for (int j = 0; j < R; j++)
          syn[i*D+k] = syn[i*D+k] ^ hard[j*D + ((k + int'(shift_of(TAB, i, j, R))) % D)];
  end

  assign zero = ~|syn;

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Frame-level LDPC iteration controller: buffers channel LLRs, sequences clear/iterate
// phases with syndrome-based early exit, then streams the hard decisions out.
module ldpc_iter_ctrl import ldpc_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int R        = R_DEF,
  parameter int C        = C_DEF,
  parameter int D        = D_DEF,
  parameter int MAX_ITER = 10,
  parameter int ITER_LAT = 4,
  parameter logic [C*R*8-1:0] SHIFT_TAB = (C*R*8)'(default_shift_tab(C, R, D)),
  localparam int IW = $clog2(MAX_ITER+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W*D-1:0]   in_llr,
  output logic [DATA_W*R*D-1:0] arr_llr,
  output logic                  arr_clr,
  output logic                  arr_run,
  input  logic [R*D-1:0]        dec_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [D-1:0]          out_bits,
  output logic                  out_last,
  output logic [IW-1:0]         out_iters,
  output logic                  out_ok
);

  localparam int BW = (R > 1) ? $clog2(R) : 1;
  localparam int LW = (ITER_LAT > 1) ? $clog2(ITER_LAT) : 1;
  localparam int GW = DATA_W*D;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat;
  logic [LW-1:0]   lat;
  logic [IW-1:0]   iter;
  logic [IW-1:0]   iter_inc;
  logic [R*D-1:0]  hard;
  logic [C*D-1:0]  syn_unused;
  logic            syn_zero;
  logic            ok;
  logic            last_beat;
  logic            last_run;

  ldpc_syndrome #(.C(C), .R(R), .D(D), .SHIFT_TAB(SHIFT_TAB)) u_syn (
    .hard (hard),
    .syn  (syn_unused),
    .zero (syn_zero)
  );

  assign last_beat = (beat == BW'(R-1));
  assign last_run  = (lat == LW'(ITER_LAT-1));
  assign iter_inc  = iter + 1'b1;
  assign out_iters = iter;
  assign out_ok    = ok;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    arr_clr   = 1'b0;
    arr_run   = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) state_nxt = CLEAR;
      end
      CLEAR: begin
        arr_clr   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        arr_run = 1'b1;
        if (last_run) state_nxt = CHECK;
      end
      CHECK: begin
        // No re-clear between iterations: the arrays keep their messages.
        if (syn_zero || iter_inc == IW'(MAX_ITER)) state_nxt = OUT;
        else                                       state_nxt = RUN;
      end
      OUT: begin
        out_valid = 1'b1;
        out_last  = last_beat;
        if (out_ready && last_beat) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    out_bits = '0;
    for (int b = 0; b < R; b++)
      if (beat == BW'(b)) out_bits = hard[b*D +: D];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat    <= '0;
      lat     <= '0;
      iter    <= '0;
      ok      <= 1'b0;
      arr_llr <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          for (int b = 0; b < R; b++)
            if (beat == BW'(b)) arr_llr[b*GW +: GW] <= in_llr;
          beat <= last_beat ? '0 : beat + 1'b1;
        end
        CLEAR: begin
          iter <= '0;
          lat  <= '0;
          ok   <= 1'b0;
        end
        RUN:   lat <= last_run ? '0 : lat + 1'b1;
        CHECK: begin
          iter <= iter_inc;
          ok   <= syn_zero;
        end
        OUT:   if (out_ready) beat <= last_beat ? '0 : beat + 1'b1;
        default: ;
      endcase
    end
  end

  // Hard decisions are sampled on the edge that closes each iteration's last RUN cycle.
  always_ff @(posedge clk) begin
    if (state == RUN && last_run) hard <= dec_in;
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl with a behavioural VNU-array model driving dec_in.
module tb_ldpc_iter_ctrl;

  localparam int DATA_W   = 8;
  localparam int R        = 5;
  localparam int C        = 3;
  localparam int D        = 8;
  localparam int MAX_ITER = 10;
  localparam int ITER_LAT = 4;
  localparam int IW       = 4;
  // Valid codeword of the default (i*j) mod 8 table: bytes 66,55,33,00,00.
  localparam logic [R*D-1:0] CW = 40'h0000335566;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W*D-1:0]   in_llr;
  logic [DATA_W*R*D-1:0] arr_llr;
  logic                  arr_clr;
  logic                  arr_run;
  logic [R*D-1:0]        dec_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [D-1:0]          out_bits;
  logic                  out_last;
  logic [IW-1:0]         out_iters;
  logic                  out_ok;

  ldpc_iter_ctrl #(.DATA_W(DATA_W), .R(R), .C(C), .D(D),
                   .MAX_ITER(MAX_ITER), .ITER_LAT(ITER_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
    .arr_llr(arr_llr), .arr_clr(arr_clr), .arr_run(arr_run), .dec_in(dec_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .out_last(out_last), .out_iters(out_iters), .out_ok(out_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int mode = 0;
  int run_cyc = 0;
  logic [DATA_W*R*D-1:0] exp_llr;

  always @(posedge clk) cyc <= cyc + 1;

  // VNU model: iteration n ends when run_cyc == n*ITER_LAT-1.
  always @(posedge clk) begin
    if (rst || arr_clr) run_cyc <= 0;
    else if (arr_run)   run_cyc <= run_cyc + 1;
  end

  always_comb begin
    dec_in = '0;
    case (mode)
      1: dec_in = 40'h1;
      2: if (run_cyc / ITER_LAT < 2) dec_in = 40'h1;
      3: dec_in = CW;
      4: dec_in = CW ^ 40'h1;
      default: dec_in = '0;
    endcase
  end

  task automatic send_frame(input int gap, output int t_last);
    t_last = -1;
    for (int b = 0; b < R; b++) begin
      in_valid = 1'b1;
      in_llr   = exp_llr[b*D*DATA_W +: D*DATA_W];
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL load_ready beat %0d: got %b want 1", b, in_ready);
      else n_pass++;
      t_last = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_llr   = '0;
      if (gap != 0 && b < R-1) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_out(output int clr_t, output int run_t, output int runs, output int ov_t);
    clr_t = -1; run_t = -1; runs = 0; ov_t = -1;
    for (int k = 0; k < 400; k++) begin
      if (arr_clr && clr_t < 0) clr_t = cyc;
      if (arr_run) begin
        runs++;
        if (run_t < 0) run_t = cyc;
      end
      if (out_valid) begin ov_t = cyc; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_timing(input string nm, input int t, input int ov_exp, input int runs_exp);
    int clr_t, run_t, runs, ov_t;
    wait_out(clr_t, run_t, runs, ov_t);
    n_total++;
    if (clr_t != t+1) $display("FAIL %s clr_cycle: got %0d want %0d", nm, clr_t, t+1); else n_pass++;
    n_total++;
    if (run_t != t+2) $display("FAIL %s run_start: got %0d want %0d", nm, run_t, t+2); else n_pass++;
    n_total++;
    if (runs != runs_exp) $display("FAIL %s run_cycles: got %0d want %0d", nm, runs, runs_exp); else n_pass++;
    n_total++;
    if (ov_t != t+ov_exp) $display("FAIL %s out_valid_cycle: got %0d want %0d (-1 = timeout)", nm, ov_t, t+ov_exp);
    else n_pass++;
  endtask

  task automatic recv_frame(input string nm, input logic [R*D-1:0] exp_word, input int exp_iters,
                            input logic exp_ok, input int stall_beat, input int stall_n);
    logic [D-1:0] exp_b;
    logic         exp_last;
    for (int b = 0; b < R; b++) begin
      exp_b    = exp_word[b*D +: D];
      exp_last = (b == R-1);
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL %s valid beat %0d: got %b want 1", nm, b, out_valid); else n_pass++;
      n_total++;
      if (out_bits !== exp_b) $display("FAIL %s bits beat %0d: got %h want %h", nm, b, out_bits, exp_b); else n_pass++;
      n_total++;
      if (out_last !== exp_last) $display("FAIL %s last beat %0d: got %b want %b", nm, b, out_last, exp_last); else n_pass++;
      n_total++;
      if (out_iters !== IW'(exp_iters)) $display("FAIL %s iters beat %0d: got %0d want %0d", nm, b, out_iters, exp_iters);
      else n_pass++;
      n_total++;
      if (out_ok !== exp_ok) $display("FAIL %s ok beat %0d: got %b want %b", nm, b, out_ok, exp_ok); else n_pass++;
      if (b == stall_beat) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_llr    = ~exp_llr[b*D*DATA_W +: D*DATA_W];
        for (int s = 0; s < stall_n; s++) begin
          @(posedge clk); #1;
          n_total++;
          if (out_valid !== 1'b1 || out_bits !== exp_b || out_last !== exp_last || out_iters !== IW'(exp_iters))
            $display("FAIL %s stall cycle %0d: valid=%b bits=%h last=%b iters=%0d want 1/%h/%b/%0d",
                     nm, s, out_valid, out_bits, out_last, out_iters, exp_b, exp_last, exp_iters);
          else n_pass++;
        end
        in_valid  = 1'b0;
        in_llr    = '0;
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL %s valid_after: got %b want 0", nm, out_valid); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL %s ready_after: got %b want 1", nm, in_ready); else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_llr = '0; out_ready = 1'b1; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (arr_clr !== 1'b0) $display("FAIL reset arr_clr: got %b want 0", arr_clr); else n_pass++;
    n_total++; if (arr_run !== 1'b0) $display("FAIL reset arr_run: got %b want 0", arr_run); else n_pass++;
    n_total++; if (arr_llr !== '0) $display("FAIL reset arr_llr: got %h want 0", arr_llr); else n_pass++;
    n_total++; if (out_ok !== 1'b0) $display("FAIL reset out_ok: got %b want 0", out_ok); else n_pass++;
    n_total++; if (out_iters !== '0) $display("FAIL reset out_iters: got %0d want 0", out_iters); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_all_zero();
    int t;
    mode = 0;
    send_frame(0, t);
    check_timing("all_zero", t, 7, 4);
    n_total++;
    if (arr_llr !== exp_llr) $display("FAIL all_zero arr_llr: got %h want %h", arr_llr, exp_llr); else n_pass++;
    recv_frame("all_zero", '0, 1, 1'b1, -1, 0);
  endtask

  task automatic test_non_conv();
    int t;
    mode = 1;
    send_frame(0, t);
    check_timing("non_conv", t, 7 + 9*(ITER_LAT+1), 40);
    recv_frame("non_conv", 40'h1, 10, 1'b0, -1, 0);
  endtask

  task automatic test_conv3();
    int t;
    mode = 2;
    send_frame(0, t);
    check_timing("conv3", t, 17, 12);
    recv_frame("conv3", '0, 3, 1'b1, -1, 0);
  endtask

  task automatic test_back_to_back();
    int t;
    mode = 3;
    send_frame(1, t);
    check_timing("gaps_stall", t, 7, 4);
    recv_frame("gaps_stall", CW, 1, 1'b1, 2, 20);
    n_total++;
    if (arr_llr !== exp_llr) $display("FAIL gaps_stall arr_llr_held: got %h want %h", arr_llr, exp_llr); else n_pass++;
  endtask

  task automatic test_flipped();
    int t;
    mode = 4;
    send_frame(0, t);
    check_timing("flipped", t, 7 + 9*(ITER_LAT+1), 40);
    recv_frame("flipped", CW ^ 40'h1, 10, 1'b0, -1, 0);
  endtask

  task automatic test_reset_mid_run();
    int t;
    mode = 1;
    send_frame(0, t);
    repeat (7) begin @(posedge clk); #1; end
    n_total++;
    if (arr_run !== 1'b1) $display("FAIL midrst run_before: got %b want 1", arr_run); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if (arr_run !== 1'b0) $display("FAIL midrst arr_run: got %b want 0", arr_run); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL midrst in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL midrst out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (arr_llr !== '0) $display("FAIL midrst arr_llr: got %h want 0", arr_llr); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    mode = 2;
    send_frame(0, t);
    check_timing("after_rst", t, 17, 12);
    recv_frame("after_rst", '0, 3, 1'b1, -1, 0);
  endtask

  initial begin
    for (int v = 0; v < R*D; v++) exp_llr[v*DATA_W +: DATA_W] = 8'(v*3 - 50);
    test_reset();
    test_all_zero();
    test_non_conv();
    test_conv3();
    test_back_to_back();
    test_flipped();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
